fir_out_decimator: RTL and testbench

Downstream stage of fir_filter. It consumes the signed N3-bit filtered_data stream, one sample per CLK while ENABLE is high. Each sample is rounded and right-shifted by SHIFT, then saturated to N2 bits. The stream is decimated by DECIM, and kept samples are buffered in a small FIFO behind a valid/ready output handshake for the next consumer (DAC/UART packer).

---
 rtl/fir_out_decimator.sv | 155 +++++++++++++++
 tb/tb_fir_out_decimator.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decimator.sv
// Rounds and saturates the fir_filter output, decimates the stream and queues
// the kept samples in a small FIFO behind a valid/ready handshake.
module fir_out_decimator #(
  parameter int N2         = 16,
  parameter int N3         = 32,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ENABLE,
  input  logic [N3-1:0]               filtered_data,
  input  logic                        CLEAR,
  output logic [N2-1:0]               DOUT,
  output logic                        DOUT_VALID,
  input  logic                        DOUT_READY,
  output logic                        OVERRUN,
  output logic [7:0]                  SAT_CNT,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic signed [N3:0] ONE     = 1;
  localparam logic signed [N3:0] HALF    = ONE <<< (SHIFT - 1);
  localparam logic signed [N3:0] SAT_MAX = (ONE <<< (N2 - 1)) - ONE;
  localparam logic signed [N3:0] SAT_MIN = -(ONE <<< (N2 - 1));

  logic [PW-1:0]      phase_reg;
  logic               s1_valid_reg, s1_clip_reg;
  logic [N2-1:0]      s1_data_reg;
  logic               s2_valid_reg, s2_clip_reg;
  logic [N2-1:0]      s2_data_reg;

  logic [N2-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]        level_reg;
  logic [N2-1:0]      dout_reg;
  logic               overrun_reg;
  logic [7:0]         sat_cnt_reg;

  logic signed [N3:0] sum_w, shifted_w;
  logic [N2-1:0]      rnd_w;
  logic               clip_w;
  logic               keep_w, pop_w, push_w, drop_w;
  logic [AW-1:0]      rd_next_w;
  logic [N2-1:0]      head_next_w;

  // One extra bit of headroom so adding the rounding constant never wraps.
  assign sum_w     = $signed({filtered_data[N3-1], filtered_data}) + HALF;
  assign shifted_w = sum_w >>> SHIFT;

  always_comb begin
    rnd_w  = shifted_w[N2-1:0];
    clip_w = 1'b0;
    if (shifted_w > SAT_MAX) begin
      rnd_w  = SAT_MAX[N2-1:0];
      clip_w = 1'b1;
    end else if (shifted_w < SAT_MIN) begin
      rnd_w  = SAT_MIN[N2-1:0];
      clip_w = 1'b1;
    end
  end

  assign keep_w    = ENABLE && (phase_reg == '0);
  assign pop_w     = (level_reg != '0) && DOUT_READY;
  assign push_w    = s2_valid_reg && ((level_reg != LEVEL_FULL) || pop_w);
  assign drop_w    = s2_valid_reg && (level_reg == LEVEL_FULL) && !pop_w;
  assign rd_next_w = rd_ptr_reg + 1'b1;

  // The head register is refilled from the next stored entry on a pop, or
  // directly from the incoming sample when it becomes the only entry.
  always_comb begin
    head_next_w = dout_reg;
    if (pop_w) begin
      if (level_reg == LEVEL_ONE) begin
        if (push_w) head_next_w = s2_data_reg;
      end else begin
        head_next_w = mem[rd_next_w];
      end
    end else if (push_w && (level_reg == '0)) begin
      head_next_w = s2_data_reg;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_clip_reg  <= 1'b0;
      s1_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_clip_reg  <= 1'b0;
      s2_data_reg  <= '0;
    end else if (CLEAR) begin
      phase_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (ENABLE) phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
      s1_valid_reg <= keep_w;
      if (keep_w) begin
        s1_data_reg <= rnd_w;
        s1_clip_reg <= clip_w;
      end
      s2_valid_reg <= s1_valid_reg;
      s2_data_reg  <= s1_data_reg;
      s2_clip_reg  <= s1_clip_reg;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      level_reg   <= '0;
      dout_reg    <= '0;
      overrun_reg <= 1'b0;
      sat_cnt_reg <= '0;
    end else if (CLEAR) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      level_reg   <= '0;
      dout_reg    <= '0;
      overrun_reg <= 1'b0;
      sat_cnt_reg <= '0;
    end else begin
      dout_reg <= head_next_w;
      if (push_w) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_w)  rd_ptr_reg <= rd_next_w;
      unique case ({push_w, pop_w})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (drop_w) overrun_reg <= 1'b1;
      if (push_w && s2_clip_reg && (sat_cnt_reg != 8'hFF)) sat_cnt_reg <= sat_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_w && !CLEAR) mem[wr_ptr_reg] <= s2_data_reg;
  end

  assign DOUT       = dout_reg;
  assign DOUT_VALID = (level_reg != '0);
  assign OVERRUN    = overrun_reg;
  assign SAT_CNT    = sat_cnt_reg;
  assign FIFO_LEVEL = level_reg;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: a DECIM=1 and a DECIM=4 instance share stimulus
// and are compared against a queue-based reference model.
module tb_fir_out_decimator;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENABLE = 1'b0;
  logic        CLEAR = 1'b0;
  logic        DOUT_READY = 1'b0;
  logic [31:0] filtered_data = '0;

  logic [15:0] dout [2];
  logic        dv   [2];
  logic        ovr  [2];
  logic [7:0]  sat  [2];
  logic [2:0]  lvl  [2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [15:0] v;
    bit          clip;
  } item_t;

  item_t       pipe [2][$];
  logic [15:0] fq   [2][$];
  bit          m_ovr [2];
  int          m_sat [2];
  int          acc_cnt [2];
  int          edge_n = 0;

  always #5 CLK = ~CLK;

  fir_out_decimator #(.DECIM(1)) u_dec1 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .filtered_data(filtered_data),
    .CLEAR(CLEAR), .DOUT(dout[0]), .DOUT_VALID(dv[0]), .DOUT_READY(DOUT_READY),
    .OVERRUN(ovr[0]), .SAT_CNT(sat[0]), .FIFO_LEVEL(lvl[0])
  );

  fir_out_decimator #(.DECIM(4)) u_dec4 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .filtered_data(filtered_data),
    .CLEAR(CLEAR), .DOUT(dout[1]), .DOUT_VALID(dv[1]), .DOUT_READY(DOUT_READY),
    .OVERRUN(ovr[1]), .SAT_CNT(sat[1]), .FIFO_LEVEL(lvl[1])
  );

  function automatic int dec_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Round half up after dividing by 256, then clamp to the 16-bit signed range.
  function automatic logic [15:0] ref_val(input logic [31:0] x, output bit clip);
    longint t, q;
    t = longint'($signed(x)) + 128;
    q = (t >= 0) ? t / 256 : -((-t + 255) / 256);
    clip = 1'b0;
    if (q > 32767) begin
      q = 32767;
      clip = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      clip = 1'b1;
    end
    return 16'(q);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pipe[i].delete();
      fq[i].delete();
      m_ovr[i]   = 1'b0;
      m_sat[i]   = 0;
      acc_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    item_t it;
    bit    pop;
    int    lvl_before;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (CLEAR) begin
        pipe[i].delete();
        fq[i].delete();
        m_ovr[i]   = 1'b0;
        m_sat[i]   = 0;
        acc_cnt[i] = 0;
      end else begin
        lvl_before = fq[i].size();
        pop = (lvl_before > 0) && DOUT_READY;
        if (pop) void'(fq[i].pop_front());
        if (pipe[i].size() > 0 && pipe[i][0].due == edge_n) begin
          it = pipe[i].pop_front();
          if (lvl_before < DEPTH || pop) begin
            fq[i].push_back(it.v);
            if (it.clip && m_sat[i] < 255) m_sat[i]++;
          end else begin
            m_ovr[i] = 1'b1;
          end
        end
        if (ENABLE) begin
          if (acc_cnt[i] % dec_of(i) == 0) begin
            it.due = edge_n + 2;
            it.v   = ref_val(filtered_data, it.clip);
            pipe[i].push_back(it);
          end
          acc_cnt[i]++;
        end
      end
    end
  endtask

  task automatic tick(input bit en, input logic [31:0] d, input bit rdy, input bit clr);
    ENABLE        = en;
    filtered_data = d;
    DOUT_READY    = rdy;
    CLEAR         = clr;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    ENABLE = 1'b0; CLEAR = 1'b0; DOUT_READY = 1'b0; filtered_data = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
    tick(0, 32'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dout[i] !== 16'h0) begin failures++; $display("FAIL reset_dout inst%0d got %h want 0000", i, dout[i]); end
      checks++;
      if (dv[i] !== 1'b0) begin failures++; $display("FAIL reset_valid inst%0d got %b want 0", i, dv[i]); end
      checks++;
      if (ovr[i] !== 1'b0) begin failures++; $display("FAIL reset_overrun inst%0d got %b want 0", i, ovr[i]); end
      checks++;
      if (sat[i] !== 8'h0) begin failures++; $display("FAIL reset_satcnt inst%0d got %0d want 0", i, sat[i]); end
      checks++;
      if (lvl[i] !== 3'd0) begin failures++; $display("FAIL reset_level inst%0d got %0d want 0", i, lvl[i]); end
    end
  endtask

  task automatic test_async_reset();
    tick(0, 32'h0, 0, 1);
    repeat (8) tick(1, 32'h7FFFFFFF, 0, 0);
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 0, 0);
    checks++;
    if (ovr[0] !== 1'b1 || lvl[0] !== 3'd4 || sat[0] !== 8'd4) begin
      failures++;
      $display("FAIL prereset_state got ovr=%b lvl=%0d sat=%0d want ovr=1 lvl=4 sat=4", ovr[0], lvl[0], sat[0]);
    end
    #3 RST = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dv[i] !== 1'b0 || lvl[i] !== 3'd0 || dout[i] !== 16'h0 || ovr[i] !== 1'b0 || sat[i] !== 8'h0) begin
        failures++;
        $display("FAIL async_reset inst%0d got dv=%b lvl=%0d dout=%h ovr=%b sat=%0d want all zero",
                 i, dv[i], lvl[i], dout[i], ovr[i], sat[i]);
      end
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
  endtask

  task automatic test_rounding();
    logic [31:0] vin  [4];
    logic [15:0] vexp [4];
    vin  = '{32'h00000180, 32'h0000017F, 32'hFFFFFE80, 32'hFFFFFE7F};
    vexp = '{16'h0002, 16'h0001, 16'hFFFF, 16'hFFFE};
    tick(0, 32'h0, 1, 1);
    for (int n = 0; n < 4; n++) begin
      tick(1, vin[n], 1, 0);
      tick(0, 32'h0, 1, 0);
      checks++;
      if (dv[0] !== 1'b0) begin failures++; $display("FAIL round_latency_early n=%0d got valid=%b want 0", n, dv[0]); end
      tick(0, 32'h0, 1, 0);
      checks++;
      if (dv[0] !== 1'b1 || dout[0] !== vexp[n]) begin
        failures++;
        $display("FAIL round_value in=%h got valid=%b dout=%h want valid=1 dout=%h", vin[n], dv[0], dout[0], vexp[n]);
      end
      tick(0, 32'h0, 1, 0);
    end
  endtask

  task automatic test_saturation();
    tick(0, 32'h0, 1, 1);
    tick(1, 32'h7FFFFFFF, 1, 0);
    tick(1, 32'h80000000, 1, 0);
    tick(1, 32'h007FFF00, 1, 0);
    checks++;
    if (dv[0] !== 1'b1 || dout[0] !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got %h want 7fff", dout[0]); end
    tick(0, 32'h0, 1, 0);
    checks++;
    if (dv[0] !== 1'b1 || dout[0] !== 16'h8000) begin failures++; $display("FAIL sat_neg got %h want 8000", dout[0]); end
    checks++;
    if (sat[0] !== 8'd2) begin failures++; $display("FAIL sat_count got %0d want 2", sat[0]); end
    tick(0, 32'h0, 1, 0);
    checks++;
    if (dv[0] !== 1'b1 || dout[0] !== 16'h7FFF) begin failures++; $display("FAIL sat_edge_value got %h want 7fff", dout[0]); end
    checks++;
    if (sat[0] !== 8'd2) begin failures++; $display("FAIL sat_count_unclipped got %0d want 2", sat[0]); end
  endtask

  task automatic test_sat_hold();
    tick(0, 32'h0, 1, 1);
    repeat (260) tick(1, 32'h80000000, 1, 0);
    repeat (3) tick(0, 32'h0, 1, 0);
    checks++;
    if (sat[0] !== 8'd255) begin failures++; $display("FAIL sat_hold got %0d want 255", sat[0]); end
    checks++;
    if (sat[1] !== 8'd65) begin failures++; $display("FAIL sat_decim4_count got %0d want 65", sat[1]); end
  endtask

  task automatic test_decimation();
    logic [15:0] got [$];
    tick(0, 32'h0, 1, 1);
    for (int k = 0; k < 16; k++) begin
      tick(1, 32'(k * 256), 1, 0);
      if (dv[1]) got.push_back(dout[1]);
      if (k == 5) begin
        repeat (3) begin
          tick(0, 32'h0, 1, 0);
          if (dv[1]) got.push_back(dout[1]);
        end
      end
    end
    repeat (4) begin
      tick(0, 32'h0, 1, 0);
      if (dv[1]) got.push_back(dout[1]);
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL decim_count got %0d want 4", got.size()); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (n >= got.size()) begin
        failures++; $display("FAIL decim_value n=%0d got none want %0d", n, 4 * n);
      end else if (got[n] !== 16'(4 * n)) begin
        failures++; $display("FAIL decim_value n=%0d got %0d want %0d", n, got[n], 4 * n);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] got [$];
    tick(0, 32'h0, 0, 1);
    for (int k = 0; k < 24; k++) tick(1, 32'(k * 256), 0, 0);
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 0, 0);
    checks++;
    if (lvl[1] !== 3'd4) begin failures++; $display("FAIL ovr_level got %0d want 4", lvl[1]); end
    checks++;
    if (ovr[1] !== 1'b1) begin failures++; $display("FAIL ovr_flag got %b want 1", ovr[1]); end
    checks++;
    if (dout[1] !== 16'd0) begin failures++; $display("FAIL ovr_head_stable got %0d want 0", dout[1]); end
    for (int n = 0; n < 8 && dv[1]; n++) begin
      got.push_back(dout[1]);
      tick(0, 32'h0, 1, 0);
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL ovr_drain_count got %0d want 4", got.size()); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (n >= got.size()) begin
        failures++; $display("FAIL ovr_drain_value n=%0d got none want %0d", n, 4 * n);
      end else if (got[n] !== 16'(4 * n)) begin
        failures++; $display("FAIL ovr_drain_value n=%0d got %0d want %0d", n, got[n], 4 * n);
      end
    end
    checks++;
    if (dv[1] !== 1'b0 || ovr[1] !== 1'b1) begin
      failures++; $display("FAIL ovr_after_drain got valid=%b ovr=%b want valid=0 ovr=1", dv[1], ovr[1]);
    end
    tick(0, 32'h0, 0, 1);
    checks++;
    if (ovr[1] !== 1'b0 || lvl[1] !== 3'd0) begin
      failures++; $display("FAIL ovr_clear got ovr=%b lvl=%0d want 0 0", ovr[1], lvl[1]);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] got [$];
    tick(0, 32'h0, 0, 1);
    for (int k = 0; k < 16; k++) tick(1, 32'(k * 256), 0, 0);
    tick(1, 32'(16 * 256), 0, 0);
    tick(0, 32'h0, 0, 0);
    checks++;
    if (lvl[1] !== 3'd4) begin failures++; $display("FAIL fullpop_prefill got %0d want 4", lvl[1]); end
    tick(0, 32'h0, 1, 0);
    checks++;
    if (lvl[1] !== 3'd4 || ovr[1] !== 1'b0 || dout[1] !== 16'd4) begin
      failures++;
      $display("FAIL fullpop_state got lvl=%0d ovr=%b dout=%0d want lvl=4 ovr=0 dout=4", lvl[1], ovr[1], dout[1]);
    end
    for (int n = 0; n < 8 && dv[1]; n++) begin
      got.push_back(dout[1]);
      tick(0, 32'h0, 1, 0);
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL fullpop_count got %0d want 4", got.size()); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (n >= got.size()) begin
        failures++; $display("FAIL fullpop_order n=%0d got none want %0d", n, 4 * (n + 1));
      end else if (got[n] !== 16'(4 * (n + 1))) begin
        failures++; $display("FAIL fullpop_order n=%0d got %0d want %0d", n, got[n], 4 * (n + 1));
      end
    end
  endtask

  task automatic test_random();
    bit          en, rdy, clr, s;
    logic [31:0] d;
    logic [31:0] edges [4];
    edges = '{32'h007FFF80, 32'h007FFF7F, 32'hFF800000, 32'hFF7FFF7F};
    tick(0, 32'h0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(0, 3) != 0);
      rdy = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 199) == 0);
      s   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = {{8{s}}, 24'($urandom)};
        2:       d = {{16{s}}, 16'($urandom)};
        default: d = edges[$urandom_range(0, 3)];
      endcase
      tick(en, d, rdy, clr);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== (fq[i].size() != 0)) begin
          failures++; $display("FAIL rnd_valid inst%0d cyc%0d got %b want %b", i, n, dv[i], fq[i].size() != 0);
        end
        checks++;
        if (lvl[i] !== 3'(fq[i].size())) begin
          failures++; $display("FAIL rnd_level inst%0d cyc%0d got %0d want %0d", i, n, lvl[i], fq[i].size());
        end
        checks++;
        if (ovr[i] !== m_ovr[i]) begin
          failures++; $display("FAIL rnd_overrun inst%0d cyc%0d got %b want %b", i, n, ovr[i], m_ovr[i]);
        end
        checks++;
        if (sat[i] !== 8'(m_sat[i])) begin
          failures++; $display("FAIL rnd_satcnt inst%0d cyc%0d got %0d want %0d", i, n, sat[i], m_sat[i]);
        end
        if (fq[i].size() != 0) begin
          checks++;
          if (dout[i] !== fq[i][0]) begin
            failures++; $display("FAIL rnd_dout inst%0d cyc%0d got %h want %h", i, n, dout[i], fq[i][0]);
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_sat_hold();
    test_decimation();
    test_overrun();
    test_full_pop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
